// File: rtl/time_pkg.sv
// Shared constants and types for the HH:MM:SS timekeeping core.
package time_pkg;

  localparam int unsigned BCD_W            = 4;
  localparam int unsigned MIN_T_MAX        = 5;
  localparam int unsigned HR_T_MAX         = 2;
  localparam int unsigned HR_WRAP_UNITS    = 3;
  localparam int unsigned TICK_DIV_DEFAULT = 100_000_000;

  // Field moduli derived from the digit limits: 60 for minutes, 24 for hours.
  localparam int unsigned MIN_MOD = (MIN_T_MAX + 1) * 10;
  localparam int unsigned HR_MOD  = HR_T_MAX * 10 + HR_WRAP_UNITS + 1;

  typedef logic [BCD_W-1:0] bcd_t;

endpackage

// File: rtl/hhmm_time_counter_if.sv
// Control and display bundle between the mode FSM/display side and the time counter.
interface hhmm_time_counter_if;
  import time_pkg::*;

  logic        en;
  logic        min_up;
  logic        min_dn;
  logic        hr_up;
  logic        hr_dn;
  bcd_t        hr_t;
  bcd_t        hr_u;
  bcd_t        min_t;
  bcd_t        min_u;
  logic [5:0]  sec;
  logic [15:0] hhmm;
  logic        min_tick;
  logic        blink;

  modport master (
    output en, min_up, min_dn, hr_up, hr_dn,
    input  hr_t, hr_u, min_t, min_u, sec, hhmm, min_tick, blink
  );

  modport slave (
    input  en, min_up, min_dn, hr_up, hr_dn,
    output hr_t, hr_u, min_t, min_u, sec, hhmm, min_tick, blink
  );

endinterface

// File: rtl/bcd_digit_pair.sv
// Two-digit BCD modulo counter with increment/decrement and a carry-out on increment wrap.
module bcd_digit_pair
  import time_pkg::*;
#(
  parameter int unsigned Modulus = 60
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic dec_i,
  output bcd_t tens_o,
  output bcd_t units_o,
  output logic carry_o
);

  localparam bcd_t TMax = bcd_t'((Modulus - 1) / 10);
  localparam bcd_t UMax = bcd_t'((Modulus - 1) % 10);

  bcd_t tens_q, tens_d;
  bcd_t units_q, units_d;
  logic at_max, at_zero, do_inc, do_dec;

  always_comb begin
    tens_d  = tens_q;
    units_d = units_q;
    do_inc  = inc_i & ~dec_i;
    do_dec  = dec_i & ~inc_i;
    at_max  = (tens_q == TMax) && (units_q == UMax);
    at_zero = (tens_q == '0) && (units_q == '0);
    carry_o = do_inc & at_max;

    if (do_inc) begin
      if (at_max) begin
        tens_d  = '0;
        units_d = '0;
      end else if (units_q == bcd_t'(9)) begin
        tens_d  = tens_q + bcd_t'(1);
        units_d = '0;
      end else begin
        units_d = units_q + bcd_t'(1);
      end
    end else if (do_dec) begin
      if (at_zero) begin
        tens_d  = TMax;
        units_d = UMax;
      end else if (units_q == '0) begin
        tens_d  = tens_q - bcd_t'(1);
        units_d = bcd_t'(9);
      end else begin
        units_d = units_q - bcd_t'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tens_q  <= '0;
      units_q <= '0;
    end else begin
      tens_q  <= tens_d;
      units_q <= units_d;
    end
  end

  assign tens_o  = tens_q;
  assign units_o = units_q;

endmodule

// File: rtl/hhmm_time_counter.sv
// 24-hour BCD time-of-day counter with prescaler, per-field adjust and decimal-point blink.
module hhmm_time_counter
  import time_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT,
  parameter int unsigned SEC_MAX  = 59
) (
  input  logic              clk,
  input  logic              rst,
  hhmm_time_counter_if.slave bus
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_HALF = PW'(TICK_DIV / 2);
  localparam logic [5:0]    SEC_LAST   = 6'(SEC_MAX);

  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    sec_q, sec_d;
  logic          min_tick_q;
  logic          blink_q, blink_d;

  logic tick, any_adj, sec_carry;
  logic min_up_v, min_dn_v, hr_up_v, hr_dn_v;
  logic min_inc, hr_inc, min_carry;
  logic unused_day_wrap;
  bcd_t min_tens, min_units, hr_tens, hr_units;

  always_comb begin
    min_up_v  = bus.min_up & ~bus.min_dn;
    min_dn_v  = bus.min_dn & ~bus.min_up;
    hr_up_v   = bus.hr_up & ~bus.hr_dn;
    hr_dn_v   = bus.hr_dn & ~bus.hr_up;
    any_adj   = min_up_v | min_dn_v | hr_up_v | hr_dn_v;
    tick      = bus.en && (presc_q == PRESC_LAST);
    // An adjust in the same cycle swallows the tick and its carry.
    sec_carry = tick && (sec_q == SEC_LAST) && !any_adj;

    presc_d = presc_q;
    sec_d   = sec_q;
    if (any_adj) begin
      presc_d = '0;
      sec_d   = '0;
    end else if (bus.en) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        sec_d = (sec_q == SEC_LAST) ? '0 : sec_q + 6'd1;
      end
    end

    blink_d = bus.en ? (presc_q < PRESC_HALF) : 1'b1;
    min_inc = min_up_v | sec_carry;
    hr_inc  = hr_up_v | (min_carry & sec_carry);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q    <= '0;
      sec_q      <= '0;
      min_tick_q <= 1'b0;
      blink_q    <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      sec_q      <= sec_d;
      min_tick_q <= sec_carry;
      blink_q    <= blink_d;
    end
  end

  bcd_digit_pair #(
    .Modulus(MIN_MOD)
  ) u_min (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (min_inc),
    .dec_i  (min_dn_v),
    .tens_o (min_tens),
    .units_o(min_units),
    .carry_o(min_carry)
  );

  // Hours wrap 23->00 with nothing downstream, so their carry-out is dropped.
  bcd_digit_pair #(
    .Modulus(HR_MOD)
  ) u_hr (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (hr_inc),
    .dec_i  (hr_dn_v),
    .tens_o (hr_tens),
    .units_o(hr_units),
    .carry_o(unused_day_wrap)
  );

  assign bus.hr_t     = hr_tens;
  assign bus.hr_u     = hr_units;
  assign bus.min_t    = min_tens;
  assign bus.min_u    = min_units;
  assign bus.sec      = sec_q;
  assign bus.hhmm     = {hr_tens, hr_units, min_tens, min_units};
  assign bus.min_tick = min_tick_q;
  assign bus.blink    = blink_q;

endmodule

// File: tb/tb_hhmm_time_counter.sv
// Bench for hhmm_time_counter: arithmetic time model checked every cycle plus directed literals.
module tb_hhmm_time_counter;

  localparam int TD  = 4;
  localparam int SM0 = 59;
  localparam int SM1 = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hhmm_time_counter_if bus ();
  hhmm_time_counter_if bus2 ();

  hhmm_time_counter #(.TICK_DIV(TD), .SEC_MAX(SM0)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  hhmm_time_counter #(.TICK_DIV(TD), .SEC_MAX(SM1)) dut_soak (
    .clk(clk),
    .rst(rst),
    .bus(bus2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: time as plain integers, one slot per DUT instance.
  int m_hr[2]    = '{0, 0};
  int m_min[2]   = '{0, 0};
  int m_sec[2]   = '{0, 0};
  int m_presc[2] = '{0, 0};
  bit m_mt[2]    = '{0, 0};
  bit m_bl[2]    = '{0, 0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got %0h want %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] pack_hm(input int h, input int m);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
  endfunction

  task automatic model_rst(input int k);
    m_hr[k] = 0; m_min[k] = 0; m_sec[k] = 0; m_presc[k] = 0; m_mt[k] = 0; m_bl[k] = 0;
  endtask

  task automatic model_step(input int k, input int sm, input logic en, input logic mu,
                            input logic md, input logic hu, input logic hd);
    bit madj, hadj, tk, carry, nbl;
    int tot;
    madj  = (mu != md);
    hadj  = (hu != hd);
    tk    = en && (m_presc[k] == TD - 1);
    nbl   = en ? (m_presc[k] < TD / 2) : 1'b1;
    carry = 0;
    if (madj || hadj) begin
      if (madj) m_min[k] = (m_min[k] + (mu ? 1 : 59)) % 60;
      if (hadj) m_hr[k] = (m_hr[k] + (hu ? 1 : 23)) % 24;
      m_sec[k]   = 0;
      m_presc[k] = 0;
    end else begin
      if (en) m_presc[k] = (m_presc[k] + 1) % TD;
      if (tk) begin
        if (m_sec[k] == sm) begin
          m_sec[k] = 0;
          carry    = 1;
        end else begin
          m_sec[k]++;
        end
      end
      if (carry) begin
        tot      = (m_hr[k] * 60 + m_min[k] + 1) % 1440;
        m_hr[k]  = tot / 60;
        m_min[k] = tot % 60;
      end
    end
    m_mt[k] = carry;
    m_bl[k] = nbl;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) model_rst(0);
    else model_step(0, SM0, bus.en, bus.min_up, bus.min_dn, bus.hr_up, bus.hr_dn);
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) model_rst(1);
    else model_step(1, SM1, bus2.en, bus2.min_up, bus2.min_dn, bus2.hr_up, bus2.hr_dn);
  end

  always @(negedge clk) begin
    chk("digits", {bus.hr_t, bus.hr_u, bus.min_t, bus.min_u}, pack_hm(m_hr[0], m_min[0]));
    chk("hhmm", bus.hhmm, pack_hm(m_hr[0], m_min[0]));
    chk("sec", bus.sec, m_sec[0]);
    chk("min_tick", bus.min_tick, m_mt[0]);
    chk("blink", bus.blink, m_bl[0]);
    chk("soak_digits", {bus2.hr_t, bus2.hr_u, bus2.min_t, bus2.min_u}, pack_hm(m_hr[1], m_min[1]));
    chk("soak_hhmm", bus2.hhmm, pack_hm(m_hr[1], m_min[1]));
    chk("soak_sec", bus2.sec, m_sec[1]);
    chk("soak_min_tick", bus2.min_tick, m_mt[1]);
    chk("soak_blink", bus2.blink, m_bl[1]);
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic mu, input logic md, input logic hu, input logic hd);
    bus.min_up = mu; bus.min_dn = md; bus.hr_up = hu; bus.hr_dn = hd;
    @(negedge clk);
    bus.min_up = 0; bus.min_dn = 0; bus.hr_up = 0; bus.hr_dn = 0;
  endtask

  // Reset is moved 2 time units off the falling edge to keep it clear of the sampler.
  task automatic do_reset();
    #2 rst = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic go(input int h, input int m);
    bus.en = 1'b0;
    do_reset();
    repeat (h) pulse(0, 0, 1, 0);
    repeat (m) pulse(1, 0, 0, 0);
  endtask

  initial begin
    #500us;
    $display("FAIL timeout t=%0t got running want finished", $time);
    $fatal(1, "bench timed out");
  end

  initial begin
    bus.en = 0; bus.min_up = 0; bus.min_dn = 0; bus.hr_up = 0; bus.hr_dn = 0;
    bus2.en = 0; bus2.min_up = 0; bus2.min_dn = 0; bus2.hr_up = 0; bus2.hr_dn = 0;
    run(2);
    chk("reset_hhmm", bus.hhmm, 16'h0000);
    chk("reset_blink", bus.blink, 1'b0);
    #2 rst = 1'b1;
    @(negedge clk);

    // Blink pattern 1,1,0,0 and first tick after four edges.
    bus.en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("blink_pat", bus.blink, ((i % 4) < 2) ? 1'b1 : 1'b0);
      if (i == 2) chk("first_tick_pre", bus.sec, 0);
      if (i == 3) chk("first_tick", bus.sec, 1);
    end

    // Asynchronous reset while counting at 12:34:20.
    go(12, 34);
    bus.en = 1'b1;
    run(80);
    chk("pre_reset_hhmm", bus.hhmm, 16'h1234);
    chk("pre_reset_sec", bus.sec, 20);
    #2 rst = 1'b0;
    #1;
    chk("async_hhmm", bus.hhmm, 16'h0000);
    chk("async_sec", bus.sec, 0);
    chk("async_blink", bus.blink, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    run(2);
    chk("post_rst_sec3", bus.sec, 0);
    run(1);
    chk("post_rst_sec4", bus.sec, 1);

    // Rollover 23:59:59 -> 00:00:00.
    go(0, 0);
    pulse(0, 0, 0, 1);
    pulse(0, 1, 0, 0);
    chk("preload", bus.hhmm, 16'h2359);
    bus.en = 1'b1;
    run(236);
    chk("roll_pre_sec", bus.sec, 59);
    chk("roll_pre_hhmm", bus.hhmm, 16'h2359);
    run(4);
    chk("roll_hhmm", bus.hhmm, 16'h0000);
    chk("roll_sec", bus.sec, 0);
    chk("roll_mt", bus.min_tick, 1'b1);
    run(1);
    chk("roll_mt_drop", bus.min_tick, 1'b0);

    // Adjust wraps.
    go(7, 0);
    pulse(0, 1, 0, 0);
    chk("min_dn_wrap", bus.hhmm, 16'h0759);
    go(23, 15);
    pulse(0, 0, 1, 0);
    chk("hr_up_wrap", bus.hhmm, 16'h0015);
    go(0, 9);
    pulse(1, 0, 0, 0);
    chk("min_bcd_carry", bus.hhmm, 16'h0010);

    // Simultaneous up+down is ignored and leaves sec alone.
    go(4, 20);
    bus.en = 1'b1;
    run(10);
    bus.en = 1'b0;
    pulse(1, 1, 0, 0);
    chk("updn_hhmm", bus.hhmm, 16'h0420);
    chk("updn_sec", bus.sec, 2);
    pulse(1, 0, 1, 0);
    chk("both_adj", bus.hhmm, 16'h0521);
    chk("both_adj_sec", bus.sec, 0);

    // Adjust on the carrying tick: tick and carry lost.
    go(10, 59);
    bus.en = 1'b1;
    run(239);
    chk("tick_adj_pre", bus.sec, 59);
    pulse(1, 0, 0, 0);
    chk("tick_adj_hhmm", bus.hhmm, 16'h1000);
    chk("tick_adj_sec", bus.sec, 0);
    chk("tick_adj_mt", bus.min_tick, 1'b0);
    run(1);
    chk("tick_adj_mt2", bus.min_tick, 1'b0);

    // Enable gating holds sec and prescaler.
    go(1, 1);
    bus.en = 1'b1;
    run(122);
    bus.en = 1'b0;
    run(20);
    chk("gate_sec", bus.sec, 30);
    chk("gate_blink", bus.blink, 1'b1);
    bus.en = 1'b1;
    run(1);
    chk("resume_sec1", bus.sec, 30);
    run(1);
    chk("resume_sec2", bus.sec, 31);
    bus.en = 1'b0;

    // Soak on the short-minute instance from 23:50 across midnight.
    do_reset();
    bus2.hr_dn = 1'b1;
    @(negedge clk);
    bus2.hr_dn = 1'b0;
    bus2.min_dn = 1'b1;
    run(10);
    bus2.min_dn = 1'b0;
    chk("soak_preload", bus2.hhmm, 16'h2350);
    bus2.en = 1'b1;
    run(400);
    chk("soak_end_hhmm", bus2.hhmm, 16'h0015);
    chk("soak_end_sec", bus2.sec, 0);
    chk("soak_end_mt", bus2.min_tick, 1'b1);
    bus2.en = 1'b0;
    run(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hhmm_time_counter.md
Name: hhmm_time_counter

Overview:
- Timekeeping core that sits directly downstream of the clock/alarm mode FSM.
- Consumes the FSM's count-enable and its decoded per-field up/down adjust pulses.
- Maintains a 24-hour HH:MM:SS time in BCD.
- Produces:
  - the four BCD digits for the 7-segment display mux,
  - a packed HHMM word for the alarm comparator,
  - a 1 Hz blink signal for the decimal point.
- Two instances are used: time-of-day (enable driven by the FSM) and alarm setpoint (enable tied low).

Parameters:
- TICK_DIV, 100000000, clk cycles per second. Must be ≥ 2. Set small in simulation.
- SEC_MAX, 59, terminal value of the seconds counter. Reduced only for simulation.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- en  input  1  count enable; 1 = time advances
- min_up  input  1  single-cycle pulse: minutes +1
- min_dn  input  1  single-cycle pulse: minutes −1
- hr_up  input  1  single-cycle pulse: hours +1
- hr_dn  input  1  single-cycle pulse: hours −1
- hr_t  output  4  hours tens digit (BCD, 0–2)
- hr_u  output  4  hours units digit (BCD, 0–9)
- min_t  output  4  minutes tens digit (BCD, 0–5)
- min_u  output  4  minutes units digit (BCD, 0–9)
- sec  output  6  binary seconds, 0..SEC_MAX
- hhmm  output  16  {hr_t, hr_u, min_t, min_u}
- min_tick  output  1  one-cycle pulse on every count-driven minute rollover
- blink  output  1  1 Hz square wave for the decimal point

Behaviour:
- Reset (rst=0, asynchronous):
  - prescaler, sec, and all digits = 0; time reads 00:00:00.
  - min_tick = 0; blink = 0.
  - Normal operation resumes on the first clk edge after rst rises.
- Prescaler:
  - When en=1, counts 0..TICK_DIV−1 and wraps.
  - Tick = prescaler at TICK_DIV−1 with en=1; it is an internal one-cycle strobe.
  - When en=0, the prescaler and sec hold their values.
- Seconds:
  - On tick: sec+1.
  - At SEC_MAX the tick sets sec to 0 and generates a minute carry.
- Minute carry:
  - min_u increments; 9→0 carries into min_t.
  - 59→00 carries into hours.
  - Hours increment; 23→00 wraps with no further carry.
  - min_tick is asserted in the cycle after the carrying tick (registered), for 1 cycle.
- Adjust pulses:
  - Honoured regardless of en.
  - Minutes wrap 59↔00 with no carry into hours.
  - Hours wrap 23↔00.
  - Units/tens BCD are handled correctly in both directions, e.g. 10→09 on down, 19→20 on up.
- Adjust side effect: any valid adjust pulse clears the prescaler and sec to 0 in the same edge, so an edited time starts a fresh minute.
- Simultaneous events:
  - min_up and min_dn both high: no minute change, no side effect.
  - Same rule for hr_up with hr_dn.
  - A valid minute adjust and a valid hour adjust in the same cycle are both applied.
  - Adjust coincident with a tick: the adjust wins. The tick and any carry are discarded and min_tick is not asserted.
- blink:
  - When en=1: blink = 1 while prescaler < TICK_DIV/2, else 0 (registered, 1-cycle latency).
  - When en=0: blink is held 1 (decimal point steady during editing).
- Latency: all outputs are registered. Digits update on the clk edge that consumes the tick or pulse; there is no combinational path from inputs to outputs.
- Invariant: digits are always legal BCD and HH ≤ 23, MM ≤ 59.

Decomposition:
- Shared package time_pkg holds:
  - BCD width (4),
  - digit limits (MIN_T_MAX=5, HR_T_MAX=2, HR_WRAP_UNITS=3),
  - the default TICK_DIV.
- One natural sub-module: bcd_digit_pair.
  - Two-digit BCD modulo counter with inc/dec inputs, a parameterised modulus (60 or 24), and a carry-out on increment wrap.
  - Instantiated twice: minutes and hours.

Test Plan (TICK_DIV=4, SEC_MAX=59 unless noted):
- Reset: drive rst low mid-count at 12:34:20 → outputs 0/0/0/0, sec=0, blink=0 immediately (asynchronously); after release with en=1, first tick arrives after 4 clk.
- Rollover: preload 23:59:59 via adjust pulses, then en=1 → after the next tick time reads 00:00:00 and min_tick is high for exactly 1 cycle.
- Adjust wrap:
  - min_dn at 07:00 → 07:59, hours unchanged.
  - hr_up at 23:15 → 00:15.
  - min_up at 00:09 → 00:10 (BCD carry between digits).
- Simultaneous:
  - min_up and min_dn in the same cycle → no change, sec not cleared.
  - hr_up with min_up → both applied.
  - Adjust on the tick cycle → tick lost, sec=0, no min_tick.
- Enable gating: en=0 for 20 clk at sec=30 → sec stays 30, blink=1; en=1 → counting resumes from the held prescaler value.
- Blink: en=1, TICK_DIV=4 → blink pattern 1,1,0,0 repeating; hhmm equals {hr_t,hr_u,min_t,min_u} throughout a 100-tick soak with SEC_MAX=3.
